cu_branch_seq: RTL and testbench
================================

Name: cu_branch_seq

Overview:
Sequential branch control unit for the LEGv8 datapath. It is the multi-cycle successor to the single-word branch decoder. It covers B, BL, BR, B.cond, CBZ and CBNZ with an explicit state register, a stall input and a taken-branch counter. It sits beside the other CU_* decoders, and the top-level control mux selects its control word whenever the instruction class is "branch".

Parameters:
LINK_REG, 30, register index written by BL
ZERO_REG, 31, register index driven on unused SA/SB
FS_PASS_A, 5'b00100, ALU function code that passes A through to set status
CNT_WIDTH, 16, width of the taken-branch counter (saturating)
ENABLE_BCOND, 1, 1 = decode B.cond; 0 = treat B.cond as illegal

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  IR holds a valid instruction routed to this unit
hold  in  1  datapath stall; freezes state and drives the idle word
opcode  in  11  IR[31:21]
cond  in  4  IR[3:0], B.cond condition code
rt_in  in  5  IR[4:0]
rn_in  in  5  IR[9:5]
status  in  4  latched NZCV {N,Z,C,V}
status_zero  in  1  live ALU zero flag
SA  out  5  register A select
SB  out  5  register B select
DA  out  5  destination register
w_reg  out  1  register file write enable
FS  out  5  ALU function select
status_load  out  1  latch NZCV this cycle
PC_FS  out  2  00 hold, 01 PC+4, 10 PC<-A bus, 11 PC+offset
PC_sel  out  1  1 = PC+4 onto data bus (link path)
IR_load  out  1  load next instruction
busy  out  1  instruction in progress (state S1)
taken  out  1  one-cycle pulse: branch redirected PC
illegal  out  1  one-cycle pulse: start with a non-branch opcode
taken_cnt  out  CNT_WIDTH  saturating count of taken branches

Behaviour:
- Decode on opcode:
  - B = [10:5]==000101
  - BL = [10:5]==100101
  - CBZ = [10:3]==10110100
  - CBNZ = [10:3]==10110101
  - B.cond = [10:3]==01010100
  - BR = 11010110000
- States: S0 (decode/issue) and S1 (resolve). The state is a 1-bit register. Reset -> S0.
- Idle word is driven in S0 with start=0, whenever hold=1, and during reset:
  - SA=SB=DA=ZERO_REG, w_reg=0, FS=0, status_load=0, PC_FS=00, PC_sel=0, IR_load=0
  - taken=0, illegal=0, busy=0
- Reset clears taken_cnt to 0. The pulses are deasserted.
- hold=1: the state does not advance and the idle word is driven. When hold returns to 0, the same state re-issues.
- S0 with start=1, single-cycle instructions. NS=S0, IR_load=1.
  - B: PC_FS=11, taken=1.
  - BR: SA=rn_in, PC_FS=10, taken=1.
  - B.cond: cond_true is computed from status using standard ARM semantics (EQ..LE, AL=1110 and 1111 both true). PC_FS=11 with taken=1 if cond_true, else PC_FS=01.
- S0 with start=1, two-cycle instructions. NS=S1, IR_load=0, PC_FS=00.
  - CBZ/CBNZ: SA=rt_in, FS=FS_PASS_A, status_load=1.
  - BL: DA=LINK_REG, PC_sel=1, w_reg=1.
- S0 with start=1 and no branch match, or B.cond with ENABLE_BCOND=0: illegal=1 for one cycle, idle word, state stays S0.
- S1 (busy=1), always returns to S0 with IR_load=1:
  - CBZ: PC_FS=11 if status_zero, else 01.
  - CBNZ: PC_FS=11 if !status_zero, else 01.
  - BL: PC_FS=11.
  - taken=1 whenever PC_FS=11.
- The decoded instruction class is registered in S0. S1 uses the registered class, not the live opcode; opcode changes during S1 are ignored.
- start is ignored in S1.
- taken_cnt increments in the cycle taken=1 and saturates at all-ones.
- Reset asserted in S1 aborts the instruction: S0 next cycle, no taken pulse, no count.
- Latency:
  - B, BR, B.cond: 1 cycle.
  - CBZ, CBNZ, BL: 2 cycles.
  - Each hold cycle adds 1.

Test Plan:
- Reset 2 cycles, then start=0 -> idle word, SA=31, PC_FS=00, taken_cnt=0, busy=0.
- CBZ rt=5, status_zero=1 in S1:
  - Cycle 0: SA=5, FS=00100, status_load=1, PC_FS=00.
  - Cycle 1: busy=1, PC_FS=11, taken=1, IR_load=1.
  - taken_cnt=1.
- CBNZ with status_zero=1 -> cycle 1 PC_FS=01, taken=0, count unchanged.
- BL -> cycle 0 DA=30, w_reg=1, PC_sel=1; cycle 1 PC_FS=11. Then BR rn=30 -> SA=30, PC_FS=10 in one cycle.
- B.cond with cond=0000 (EQ): status=0100 -> PC_FS=11; status=0000 -> PC_FS=01. Opcode 10001011000 (ADD) -> illegal=1, idle word.
- Stall and reset cases:
  - hold=1 for 3 cycles mid-CBZ in S1 -> state stays S1 and the idle word is driven. Release -> resolves correctly.
  - reset in S1 -> S0, no taken.
  - CNT_WIDTH=2 with 5 taken branches -> taken_cnt=3.

Source files
------------

// File: rtl/cu_branch_seq_if.sv
// cu_branch_seq_if: instruction fields, flags and control word of the branch control unit
interface cu_branch_seq_if #(parameter int CNT_WIDTH = 16);
    logic                 start;
    logic                 hold;
    logic [10:0]          opcode;
    logic [3:0]           cond;
    logic [4:0]           rt_in;
    logic [4:0]           rn_in;
    logic [3:0]           status;
    logic                 status_zero;
    logic [4:0]           SA;
    logic [4:0]           SB;
    logic [4:0]           DA;
    logic                 w_reg;
    logic [4:0]           FS;
    logic                 status_load;
    logic [1:0]           PC_FS;
    logic                 PC_sel;
    logic                 IR_load;
    logic                 busy;
    logic                 taken;
    logic                 illegal;
    logic [CNT_WIDTH-1:0] taken_cnt;
    modport master (
        output start, hold, opcode, cond, rt_in, rn_in, status, status_zero,
        input  SA, SB, DA, w_reg, FS, status_load, PC_FS, PC_sel, IR_load,
               busy, taken, illegal, taken_cnt
    );
    modport slave (
        input  start, hold, opcode, cond, rt_in, rn_in, status, status_zero,
        output SA, SB, DA, w_reg, FS, status_load, PC_FS, PC_sel, IR_load,
               busy, taken, illegal, taken_cnt
    );
endinterface

// File: rtl/cu_branch_seq.sv
// cu_branch_seq: two-state LEGv8 branch control unit (B, BL, BR, B.cond, CBZ, CBNZ)
module cu_branch_seq #(
    parameter logic [4:0] LINK_REG     = 5'd30,
    parameter logic [4:0] ZERO_REG     = 5'd31,
    parameter logic [4:0] FS_PASS_A    = 5'b00100,
    parameter int         CNT_WIDTH    = 16,
    parameter bit         ENABLE_BCOND = 1'b1
) (
    input logic           clock,
    input logic           reset,
    cu_branch_seq_if.slave b
);
    typedef enum logic {S0, S1} state_t;
    typedef enum logic [1:0] {K_CBZ, K_CBNZ, K_BL} kind_t;

    state_t               state;
    kind_t                kind;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 tk;

    wire is_b     = b.opcode[10:5] == 6'b000101;
    wire is_bl    = b.opcode[10:5] == 6'b100101;
    wire is_cbz   = b.opcode[10:3] == 8'b10110100;
    wire is_cbnz  = b.opcode[10:3] == 8'b10110101;
    wire is_bcond = ENABLE_BCOND && b.opcode[10:3] == 8'b01010100;
    wire is_br    = b.opcode == 11'b11010110000;
    wire is_cb    = is_cbz | is_cbnz;

    // ARM condition: even codes select a base test, odd codes invert it, 111x is always true
    wire n = b.status[3], z = b.status[2], c = b.status[1], v = b.status[0];
    wire [7:0] base = {1'b1, ~z & (n == v), n == v, c & ~z, v, n, c, z};
    wire cond_true  = base[b.cond[3:1]] ^ (b.cond[0] & (b.cond[3:1] != 3'b111));

    wire res_take = kind == K_BL || (kind == K_CBZ && b.status_zero) || (kind == K_CBNZ && !b.status_zero);

    always_comb begin
        b.SA = ZERO_REG;
        b.SB = ZERO_REG;
        b.DA = ZERO_REG;
        b.w_reg = 1'b0;
        b.FS = 5'd0;
        b.status_load = 1'b0;
        b.PC_FS = 2'b00;
        b.PC_sel = 1'b0;
        b.IR_load = 1'b0;
        b.busy = 1'b0;
        b.illegal = 1'b0;
        tk = 1'b0;
        if (!reset && !b.hold) begin
            if (state == S1) begin
                b.busy = 1'b1;
                b.IR_load = 1'b1;
                tk = res_take;
                b.PC_FS = res_take ? 2'b11 : 2'b01;
            end else if (b.start) begin
                if (is_b || is_br || is_bcond) begin
                    b.IR_load = 1'b1;
                    tk = is_b || is_br || cond_true;
                    b.PC_FS = is_br ? 2'b10 : (tk ? 2'b11 : 2'b01);
                    b.SA = is_br ? b.rn_in : ZERO_REG;
                end else if (is_cb) begin
                    b.SA = b.rt_in;
                    b.FS = FS_PASS_A;
                    b.status_load = 1'b1;
                end else if (is_bl) begin
                    b.DA = LINK_REG;
                    b.PC_sel = 1'b1;
                    b.w_reg = 1'b1;
                end else begin
                    b.illegal = 1'b1;
                end
            end
        end
    end

    assign b.taken = tk;
    assign b.taken_cnt = cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S0;
            kind <= K_CBZ;
            cnt <= '0;
        end else begin
            if (!b.hold) begin
                if (state == S1) begin
                    state <= S0;
                end else if (b.start && (is_cb || is_bl)) begin
                    state <= S1;
                    kind <= is_bl ? K_BL : (is_cbz ? K_CBZ : K_CBNZ);
                end
            end
            if (tk && cnt != '1) cnt <= cnt + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_cu_branch_seq.sv
// tb_cu_branch_seq: directed stimulus with a queued scoreboard checked by a negedge monitor
module tb_cu_branch_seq;
    typedef struct packed {
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [4:0]  da;
        logic [4:0]  fs;
        logic [1:0]  pcfs;
        logic [6:0]  fl;
        logic [15:0] cnt;
    } word_t;

    localparam logic [6:0] W = 7'b1000000, SL = 7'b0100000, PS = 7'b0010000, IRL = 7'b0001000;
    localparam logic [6:0] BSY = 7'b0000100, TK = 7'b0000010, ILL = 7'b0000001, NONE = 7'b0;
    localparam logic [10:0] OP_B = 11'b00010111111, OP_BL = 11'b10010100000;
    localparam logic [10:0] OP_CBZ = 11'b10110100000, OP_CBNZ = 11'b10110101000;
    localparam logic [10:0] OP_BC = 11'b01010100000, OP_BR = 11'b11010110000, OP_ADD = 11'b10001011000;

    logic clock = 1'b0;
    logic reset;
    int   pass = 0;
    int   total = 0;
    int   mcnt = 0;
    word_t eq[$];
    string nq[$];

    always #5 clock = ~clock;

    cu_branch_seq_if #(.CNT_WIDTH(16)) i ();
    cu_branch_seq_if #(.CNT_WIDTH(2))  i2 ();

    assign i2.start = i.start;
    assign i2.hold = i.hold;
    assign i2.opcode = i.opcode;
    assign i2.cond = i.cond;
    assign i2.rt_in = i.rt_in;
    assign i2.rn_in = i.rn_in;
    assign i2.status = i.status;
    assign i2.status_zero = i.status_zero;

    cu_branch_seq dut (.clock(clock), .reset(reset), .b(i.slave));
    cu_branch_seq #(.CNT_WIDTH(2)) dut2 (.clock(clock), .reset(reset), .b(i2.slave));

    function automatic word_t mk(input logic [4:0] sa, input logic [4:0] da, input logic [4:0] fs,
                                 input logic [1:0] pcfs, input logic [6:0] fl);
        mk = '{sa: sa, sb: 5'd31, da: da, fs: fs, pcfs: pcfs, fl: fl, cnt: 16'd0};
    endfunction

    task automatic tick(input string nm, input word_t w);
        w.cnt = mcnt[15:0];
        eq.push_back(w);
        nq.push_back(nm);
        if (w.fl[1]) mcnt++;
        if (reset) mcnt = 0;
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        word_t e, a;
        string n;
        if (eq.size() != 0) begin
            e = eq.pop_front();
            n = nq.pop_front();
            a = '{sa: i.SA, sb: i.SB, da: i.DA, fs: i.FS, pcfs: i.PC_FS,
                  fl: {i.w_reg, i.status_load, i.PC_sel, i.IR_load, i.busy, i.taken, i.illegal},
                  cnt: i.taken_cnt};
            total++;
            if (a === e) pass++;
            else $display("FAIL %s: got %h expected %h", n, a, e);
        end
    end

    typedef struct { logic [3:0] cond; logic [3:0] st; bit t; } bc_t;
    bc_t bc[12] = '{
        '{4'b0000, 4'b0100, 1}, '{4'b0000, 4'b0000, 0}, '{4'b0001, 4'b0100, 0},
        '{4'b1100, 4'b1001, 1}, '{4'b1101, 4'b1001, 0}, '{4'b1011, 4'b1000, 1},
        '{4'b1000, 4'b0010, 1}, '{4'b1001, 4'b0010, 0}, '{4'b1110, 4'b0000, 1},
        '{4'b1111, 4'b0000, 1}, '{4'b0110, 4'b0001, 1}, '{4'b0011, 4'b0010, 0}
    };

    initial begin
        reset = 1'b1;
        i.start = 1'b0; i.hold = 1'b0; i.opcode = '0; i.cond = '0;
        i.rt_in = '0; i.rn_in = '0; i.status = '0; i.status_zero = 1'b0;
        @(posedge clock);
        #1;
        tick("reset", mk(31, 31, 0, 2'b00, NONE));
        reset = 1'b0;
        tick("idle", mk(31, 31, 0, 2'b00, NONE));
        i.start = 1'b1; i.opcode = OP_CBZ; i.rt_in = 5'd5;
        tick("cbz_c0", mk(5, 31, 5'b00100, 2'b00, SL));
        i.start = 1'b0; i.status_zero = 1'b1;
        tick("cbz_c1", mk(31, 31, 0, 2'b11, BSY | IRL | TK));
        tick("cbz_cnt", mk(31, 31, 0, 2'b00, NONE));
        i.start = 1'b1; i.opcode = OP_CBNZ;
        tick("cbnz_c0", mk(5, 31, 5'b00100, 2'b00, SL));
        i.opcode = OP_ADD;
        tick("cbnz_c1", mk(31, 31, 0, 2'b01, BSY | IRL));
        i.opcode = OP_BL;
        tick("bl_c0", mk(31, 30, 0, 2'b00, W | PS));
        i.start = 1'b0;
        tick("bl_c1", mk(31, 31, 0, 2'b11, BSY | IRL | TK));
        i.start = 1'b1; i.opcode = OP_BR; i.rn_in = 5'd30;
        tick("br", mk(30, 31, 0, 2'b10, IRL | TK));
        i.opcode = OP_B;
        tick("b", mk(31, 31, 0, 2'b11, IRL | TK));
        i.opcode = OP_BC;
        foreach (bc[k]) begin
            i.cond = bc[k].cond; i.status = bc[k].st;
            tick($sformatf("bcond_%0d", k), mk(31, 31, 0, bc[k].t ? 2'b11 : 2'b01, bc[k].t ? IRL | TK : IRL));
        end
        i.opcode = OP_ADD;
        tick("illegal", mk(31, 31, 0, 2'b00, ILL));
        i.opcode = OP_CBZ; i.hold = 1'b1;
        tick("hold_s0", mk(31, 31, 0, 2'b00, NONE));
        i.hold = 1'b0;
        tick("hold_c0", mk(5, 31, 5'b00100, 2'b00, SL));
        i.start = 1'b0; i.hold = 1'b1;
        for (int k = 0; k < 3; k++) tick("hold_s1", mk(31, 31, 0, 2'b00, NONE));
        i.hold = 1'b0;
        tick("hold_rel", mk(31, 31, 0, 2'b11, BSY | IRL | TK));
        tick("hold_done", mk(31, 31, 0, 2'b00, NONE));
        i.start = 1'b1;
        tick("rst_c0", mk(5, 31, 5'b00100, 2'b00, SL));
        i.start = 1'b0; reset = 1'b1;
        tick("rst_s1", mk(31, 31, 0, 2'b00, NONE));
        reset = 1'b0;
        tick("rst_after", mk(31, 31, 0, 2'b00, NONE));
        i.start = 1'b1; i.opcode = OP_B;
        for (int k = 0; k < 5; k++) tick("b_run", mk(31, 31, 0, 2'b11, IRL | TK));
        i.start = 1'b0;
        tick("cnt5", mk(31, 31, 0, 2'b00, NONE));
        @(negedge clock);
        total++;
        if (i2.taken_cnt === 2'd3) pass++;
        else $display("FAIL sat_cnt: got %0d expected 3", i2.taken_cnt);
        total++;
        if (eq.size() == 0) pass++;
        else $display("FAIL drain: got %0d pending expected 0", eq.size());
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
